// File: rtl/jtframe_cen_meter_pkg.sv
// Shared definitions for the clock-enable rate/phase meter: FSM state
// encoding and the saturating-increment rule used by every pulse counter.
package jtframe_cen_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_REPORT  = 2'd3
    } state_t;

    // A counter advances only when a pulse arrives and it is not already
    // all-ones; callers pass the reduction-AND of their own count so the
    // rule stays independent of counter width.
    function automatic logic sat_step(input logic inc, input logic at_max);
        return inc & ~at_max;
    endfunction

endpackage

// File: rtl/jtframe_sat_cnt.sv
// Saturating up-counter with synchronous clear; stops at all-ones.
module jtframe_sat_cnt
    import jtframe_cen_meter_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Count pulses, clear on request, hold once saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (sat_step(inc, &q)) begin
            q <= q + ONE;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/jtframe_cen_meter.sv
// Measures how many cen/cenb pulses fall inside a window aligned to the
// first cen, checks them against an expected range, and flags broken
// cen/cenb interleaving or a cen source that never fires.
module jtframe_cen_meter
    import jtframe_cen_meter_pkg::*;
#(
    parameter int CW = 16,
    parameter int WW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          cenb,
    input  logic          start,
    input  logic [WW-1:0] win,
    input  logic [CW-1:0] exp_lo,
    input  logic [CW-1:0] exp_hi,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cntb,
    output logic          err_lo,
    output logic          err_hi,
    output logic          err_phase,
    output logic          stall
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WW-1:0] WIN_ONE = {{(WW-1){1'b0}}, 1'b1};

    state_t        state;
    logic [WW-1:0] win_r;
    logic [WW-1:0] wcnt_r;
    logic [CW-1:0] exp_lo_r;
    logic [CW-1:0] exp_hi_r;
    logic          phase_r;
    logic          cenb_seen_r;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cntb_q;
    logic [CW-1:0] cnt_nx_s;
    logic [CW-1:0] cntb_nx_s;
    logic          cen_hit_s;
    logic          cenb_hit_s;
    logic          clr_s;
    logic          viol_s;
    logic          phase_nx_s;
    logic          go_report_s;
    logic          stall_hit_s;

    jtframe_sat_cnt #(.W(CW)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_s),
        .inc (cen_hit_s),
        .q   (cnt_q)
    );

    jtframe_sat_cnt #(.W(CW)) u_cntb (
        .clk (clk),
        .rst (rst),
        .clr (clr_s),
        .inc (cenb_hit_s),
        .q   (cntb_q)
    );

    // Decode which pulses count this cycle, phase violations and window end.
    always_comb begin
        cen_hit_s   = 1'b0;
        cenb_hit_s  = 1'b0;
        clr_s       = 1'b0;
        viol_s      = 1'b0;
        go_report_s = 1'b0;
        stall_hit_s = 1'b0;
        case (state)
            ST_IDLE: begin
                clr_s = start;
            end
            ST_ARM: begin
                // The aligning cen is the phase reference; only a
                // coincident cenb can be wrong here. cenb before the
                // reference is outside the window and not counted.
                cen_hit_s = cen;
                viol_s    = cen & cenb;
                if (cen) begin
                    go_report_s = (win_r == WIN_ONE);
                end else begin
                    go_report_s = (wcnt_r == WIN_ONE);
                    stall_hit_s = (wcnt_r == WIN_ONE);
                end
            end
            ST_MEASURE: begin
                cen_hit_s   = cen;
                cenb_hit_s  = cenb;
                viol_s      = (cen & cenb) | (cen & ~cenb_seen_r);
                go_report_s = (wcnt_r == WIN_ONE);
            end
            default: begin
                clr_s = 1'b0;
            end
        endcase
        // Value the counters will hold after this edge, so results can be
        // published in the same edge that enters REPORT.
        cnt_nx_s   = sat_step(cen_hit_s,  &cnt_q)  ? cnt_q  + CNT_ONE : cnt_q;
        cntb_nx_s  = sat_step(cenb_hit_s, &cntb_q) ? cntb_q + CNT_ONE : cntb_q;
        phase_nx_s = phase_r | viol_s;
    end

    // Measurement FSM, window/timeout counter, phase tracker and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            win_r       <= '0;
            wcnt_r      <= '0;
            exp_lo_r    <= '0;
            exp_hi_r    <= '0;
            phase_r     <= 1'b0;
            cenb_seen_r <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cnt         <= '0;
            cntb        <= '0;
            err_lo      <= 1'b0;
            err_hi      <= 1'b0;
            err_phase   <= 1'b0;
            stall       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        win_r       <= win;
                        exp_lo_r    <= exp_lo;
                        exp_hi_r    <= exp_hi;
                        wcnt_r      <= win;
                        phase_r     <= 1'b0;
                        cenb_seen_r <= 1'b0;
                        if (win == '0) begin
                            // Empty window: report zero counts right away.
                            state     <= ST_REPORT;
                            done      <= 1'b1;
                            cnt       <= '0;
                            cntb      <= '0;
                            err_lo    <= (exp_lo != '0);
                            err_hi    <= 1'b0;
                            err_phase <= 1'b0;
                            stall     <= 1'b0;
                        end else begin
                            state <= ST_ARM;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_ARM: begin
                    if (cen) begin
                        phase_r     <= phase_nx_s;
                        cenb_seen_r <= 1'b0;
                        wcnt_r      <= win_r - WIN_ONE;
                        state       <= go_report_s ? ST_REPORT : ST_MEASURE;
                    end else if (go_report_s) begin
                        state <= ST_REPORT;
                    end else begin
                        wcnt_r <= wcnt_r - WIN_ONE;
                    end
                end
                ST_MEASURE: begin
                    phase_r <= phase_nx_s;
                    if (cen) begin
                        cenb_seen_r <= 1'b0;
                    end else if (cenb) begin
                        cenb_seen_r <= 1'b1;
                    end
                    wcnt_r <= wcnt_r - WIN_ONE;
                    if (go_report_s) begin
                        state <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // Publish results on the edge that enters REPORT.
            if (go_report_s) begin
                done      <= 1'b1;
                cnt       <= cnt_nx_s;
                cntb      <= cntb_nx_s;
                err_lo    <= (cnt_nx_s < exp_lo_r);
                err_hi    <= (cnt_nx_s > exp_hi_r);
                err_phase <= phase_nx_s;
                stall     <= stall_hit_s;
            end
        end
    end

endmodule
